// File: rtl/uart16550_cfifo_if.sv
// Register-file / serialiser side bundle for the UART16550 circular FIFO.
// master = producer/consumer logic driving push/pop; slave = the FIFO itself.
interface uart16550_cfifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  rst_i;
  logic                  ena_i;
  logic                  push_i;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] d_i;
  logic [DATA_WIDTH-1:0] q_o;
  logic [CW-1:0]         level_o;
  logic                  empty_o;
  logic                  full_o;
  logic [CW-1:0]         trigger_lvl_i;
  logic                  trigger_o;
  logic                  error_o;
  logic                  clr_i;
  logic                  overrun_o;
  logic                  underrun_o;

  modport slave (
    input  rst_i, ena_i, push_i, pop_i, d_i, trigger_lvl_i, clr_i,
    output q_o, level_o, empty_o, full_o, trigger_o, error_o, overrun_o, underrun_o
  );

  modport master (
    output rst_i, ena_i, push_i, pop_i, d_i, trigger_lvl_i, clr_i,
    input  q_o, level_o, empty_o, full_o, trigger_o, error_o, overrun_o, underrun_o
  );
endinterface

// File: rtl/uart16550_cfifo.sv
// Circular-buffer FIFO for the UART16550 TX/RX paths: exact fill level,
// error-entry count, programmable trigger, sticky overrun/underrun and a
// 16450 single-entry mode selected by ena_i.
module uart16550_cfifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ERR_BITS   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  uart16550_cfifo_if.slave  f
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         cnt, err_cnt;
  logic                  overrun_q, underrun_q;
  logic [CW-1:0]         eff_depth;
  logic                  push, pop, err_in, err_out;

  // An entry is "erroneous" when any of its top ERR_BITS bits is set.
  if (ERR_BITS > 0) begin : g_err
    assign err_in  = |f.d_i[DATA_WIDTH-1 -: ERR_BITS];
    assign err_out = |mem[rptr][DATA_WIDTH-1 -: ERR_BITS];
  end else begin : g_noerr
    assign err_in  = 1'b0;
    assign err_out = 1'b0;
  end

  // 16450 mode shrinks the usable depth to one entry; full uses >= so a
  // FIFO left with several entries after a mode drop still refuses pushes.
  assign eff_depth = f.ena_i ? CW'(FIFO_DEPTH) : CW'(1);
  assign f.full_o  = (cnt >= eff_depth);
  assign f.empty_o = (cnt == '0);
  assign pop       = f.pop_i & ~f.empty_o;
  // A push into a full FIFO is fine when the same cycle frees a slot.
  assign push      = f.push_i & (~f.full_o | pop);

  assign f.q_o        = mem[rptr];
  assign f.level_o    = cnt;
  assign f.trigger_o  = (f.trigger_lvl_i != '0) && (cnt >= f.trigger_lvl_i);
  assign f.error_o    = (err_cnt != '0);
  assign f.overrun_o  = overrun_q;
  assign f.underrun_o = underrun_q;

  // Storage array, deliberately without reset.
  always_ff @(posedge clk_i) begin
    if (push && !f.rst_i) mem[wptr] <= f.d_i;
  end

  // Pointers, counters and sticky flags; flush overrides any push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (f.rst_i) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({push & err_in, pop & err_out})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
      // A new rejection in the clear cycle must not be lost.
      overrun_q  <= (overrun_q  & ~f.clr_i) | (f.push_i & ~push);
      underrun_q <= (underrun_q & ~f.clr_i) | (f.pop_i  & ~pop);
    end
  end
endmodule

// File: tb/tb_uart16550_cfifo.sv
// Directed bench for uart16550_cfifo (RX-width instance, 11-bit entries).
module tb_uart16550_cfifo;
  localparam int DW = 11;
  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart16550_cfifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) f ();

  uart16550_cfifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ERR_BITS(3)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .f      (f)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given push/pop/data; sample point is #1 after the edge.
  task automatic cyc(input logic p, input logic o, input int d);
    f.push_i = p;
    f.pop_i  = o;
    f.d_i    = d[DW-1:0];
    @(posedge clk_i);
    #1;
    f.push_i = 1'b0;
    f.pop_i  = 1'b0;
  endtask

  task automatic flush();
    f.rst_i = 1'b1;
    cyc(1'b0, 1'b0, 0);
    f.rst_i = 1'b0;
  endtask

  task automatic clear();
    f.clr_i = 1'b1;
    cyc(1'b0, 1'b0, 0);
    f.clr_i = 1'b0;
  endtask

  initial begin
    f.rst_i = 1'b0; f.ena_i = 1'b1; f.push_i = 1'b0; f.pop_i = 1'b0;
    f.d_i = '0; f.trigger_lvl_i = 5'd8; f.clr_i = 1'b0;
    #12;
    chk("rst_empty", int'(f.empty_o), 1);
    chk("rst_full", int'(f.full_o), 0);
    chk("rst_level", int'(f.level_o), 0);
    chk("rst_trig", int'(f.trigger_o), 0);
    chk("rst_err", int'(f.error_o), 0);
    chk("rst_ovr", int'(f.overrun_o), 0);
    chk("rst_udr", int'(f.underrun_o), 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fill/drain with trigger at 8.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, i);
      chk("fill_level", int'(f.level_o), i);
      chk("fill_trig", int'(f.trigger_o), (i >= 8) ? 1 : 0);
      chk("fill_full", int'(f.full_o), (i == 16) ? 1 : 0);
      chk("fill_head", int'(f.q_o), 1);
    end
    cyc(1'b1, 1'b0, 'h11);
    chk("ovf_level", int'(f.level_o), 16);
    chk("ovf_flag", int'(f.overrun_o), 1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_q", int'(f.q_o), i);
      cyc(1'b0, 1'b1, 0);
      chk("drain_level", int'(f.level_o), 16 - i);
      chk("drain_trig", int'(f.trigger_o), ((16 - i) >= 8) ? 1 : 0);
    end
    chk("drain_empty", int'(f.empty_o), 1);
    chk("drain_ovr_sticky", int'(f.overrun_o), 1);
    chk("drain_udr0", int'(f.underrun_o), 0);
    cyc(1'b0, 1'b1, 0);
    chk("udr_flag", int'(f.underrun_o), 1);
    chk("udr_level", int'(f.level_o), 0);
    clear();
    chk("clr_ovr", int'(f.overrun_o), 0);
    chk("clr_udr", int'(f.underrun_o), 0);
    // Set event coinciding with clear wins.
    f.clr_i = 1'b1;
    cyc(1'b0, 1'b1, 0);
    f.clr_i = 1'b0;
    chk("clr_vs_set", int'(f.underrun_o), 1);
    clear();
    chk("clr_again", int'(f.underrun_o), 0);

    // Wrap-around: advance pointers by 10, then run a full 16 through.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, i);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 0);
    chk("wrap_empty", int'(f.empty_o), 1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 'hA0 + i);
    chk("wrap_full", int'(f.full_o), 1);
    for (int i = 0; i < 16; i++) begin
      chk("wrap_q", int'(f.q_o), 'hA0 + i);
      chk("wrap_level", int'(f.level_o), 16 - i);
      cyc(1'b0, 1'b1, 0);
    end
    chk("wrap_end", int'(f.level_o), 0);

    // Simultaneous push/pop at full, then at empty.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, i);
    cyc(1'b1, 1'b1, 'h55);
    chk("sim_full_level", int'(f.level_o), 16);
    chk("sim_full_ovr", int'(f.overrun_o), 0);
    chk("sim_full_full", int'(f.full_o), 1);
    for (int i = 2; i <= 16; i++) begin
      chk("sim_q", int'(f.q_o), i);
      cyc(1'b0, 1'b1, 0);
    end
    chk("sim_last", int'(f.q_o), 'h55);
    cyc(1'b0, 1'b1, 0);
    chk("sim_drained", int'(f.empty_o), 1);
    cyc(1'b1, 1'b1, 'h66);
    chk("sim_empty_level", int'(f.level_o), 1);
    chk("sim_empty_udr", int'(f.underrun_o), 1);
    chk("sim_empty_q", int'(f.q_o), 'h66);
    cyc(1'b0, 1'b1, 0);
    clear();

    // Error-entry tracking.
    cyc(1'b1, 1'b0, 'h0AA);
    chk("err_clean", int'(f.error_o), 0);
    cyc(1'b1, 1'b0, 'h4BB);
    cyc(1'b1, 1'b0, 'h0CC);
    chk("err_set", int'(f.error_o), 1);
    cyc(1'b0, 1'b1, 0);
    chk("err_still", int'(f.error_o), 1);
    cyc(1'b0, 1'b1, 0);
    chk("err_gone", int'(f.error_o), 0);
    cyc(1'b1, 1'b0, 'h7FF);
    cyc(1'b0, 1'b1, 0);
    chk("err_head", int'(f.q_o), 'h7FF);
    cyc(1'b1, 1'b1, 'h500);
    chk("err_cancel", int'(f.error_o), 1);
    chk("err_cancel_q", int'(f.q_o), 'h500);
    chk("err_cancel_lvl", int'(f.level_o), 1);
    cyc(1'b0, 1'b1, 0);
    chk("err_final", int'(f.error_o), 0);

    // Trigger disabled, then flush with a push pending at level 5.
    f.trigger_lvl_i = 5'd0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, i);
      chk("trig0", int'(f.trigger_o), 0);
    end
    f.rst_i = 1'b1;
    cyc(1'b1, 1'b0, 'h77);
    f.rst_i = 1'b0;
    chk("flush_level", int'(f.level_o), 0);
    chk("flush_empty", int'(f.empty_o), 1);
    f.trigger_lvl_i = 5'd8;

    // 16450 mode: depth of one.
    f.ena_i = 1'b0;
    cyc(1'b1, 1'b0, 'h31);
    chk("m0_full", int'(f.full_o), 1);
    cyc(1'b1, 1'b0, 'h32);
    chk("m0_ovr", int'(f.overrun_o), 1);
    chk("m0_level", int'(f.level_o), 1);
    chk("m0_q", int'(f.q_o), 'h31);
    flush();
    chk("m0_flush_ovr", int'(f.overrun_o), 0);

    // Dropping ena_i with three entries keeps them and blocks pushes.
    f.ena_i = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 'h40 + i);
    f.ena_i = 1'b0;
    #1;
    chk("msw_full", int'(f.full_o), 1);
    cyc(1'b1, 1'b0, 'h4F);
    chk("msw_rej", int'(f.level_o), 3);
    for (int i = 1; i <= 3; i++) begin
      chk("msw_q", int'(f.q_o), 'h40 + i);
      cyc(1'b0, 1'b1, 0);
      chk("msw_full_after", int'(f.full_o), (i < 3) ? 1 : 0);
    end
    f.ena_i = 1'b1;
    flush();

    // Asynchronous reset mid-stream.
    cyc(1'b0, 1'b1, 0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 'h400 + i);
    chk("pre_arst_udr", int'(f.underrun_o), 1);
    chk("pre_arst_trig", int'(f.trigger_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_empty", int'(f.empty_o), 1);
    chk("arst_level", int'(f.level_o), 0);
    chk("arst_trig", int'(f.trigger_o), 0);
    chk("arst_err", int'(f.error_o), 0);
    chk("arst_udr", int'(f.underrun_o), 0);
    chk("arst_full", int'(f.full_o), 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
